// File: rtl/pipeline_pkg.sv
// Shared widths for the 5-stage pipeline.
package pipeline_pkg;

   localparam int unsigned REG_IDX_W       = 5;
   localparam int unsigned DATA_W          = 32;
   localparam int unsigned DMEM_ADDR_WIDTH = 8;

endpackage : pipeline_pkg

// File: rtl/data_memory.sv
// Word-addressed synchronous read-first data RAM with read-enable.
// Only the read-data register is reset; the array itself is not.
module data_memory
   import pipeline_pkg::*;
#(
   parameter int unsigned AW = DMEM_ADDR_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              re,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Array write; the caller already qualifies we with stall/reset/alignment.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   // Read-first output register: a concurrent write is not visible until the next read.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule : data_memory

// File: rtl/mem_wb_stage.sv
// MEM stage (data memory access, branch resolve) plus the MEM/WB pipeline register.
module mem_wb_stage
   import pipeline_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic [DATA_W-1:0]    PC_next_MEM,
   input  logic [DATA_W-1:0]    resultadoALU_MEM,
   input  logic [DATA_W-1:0]    Read_Data_2_MEM,
   input  logic                 Branch_MEM,
   input  logic                 MemRead_MEM,
   input  logic                 MemToReg_MEM,
   input  logic                 MemWrite_MEM,
   input  logic                 RegWrite_MEM,
   input  logic                 Zero_MEM,
   input  logic [REG_IDX_W-1:0] Write_register_MEM,
   output logic                 PCSrc_MEM,
   output logic [DATA_W-1:0]    PC_target_MEM,
   output logic [DATA_W-1:0]    Read_Data_WB,
   output logic [DATA_W-1:0]    resultadoALU_WB,
   output logic [REG_IDX_W-1:0] Write_register_WB,
   output logic                 RegWrite_WB,
   output logic                 MemToReg_WB,
   output logic                 misaligned_WB
);

   logic                  misaligned_c;
   logic                  dmem_we;
   logic [ADDR_WIDTH-1:0] dmem_addr;

   logic [DATA_W-1:0]     alu_q,        alu_d;
   logic [REG_IDX_W-1:0]  wreg_q,       wreg_d;
   logic                  regwrite_q,   regwrite_d;
   logic                  memtoreg_q,   memtoreg_d;
   logic                  misaligned_q, misaligned_d;

   // Access checks and branch resolution; upper address bits fold onto the array.
   always_comb begin
      misaligned_c = (MemRead_MEM | MemWrite_MEM) & (resultadoALU_MEM[1:0] != 2'b00);
      dmem_addr    = resultadoALU_MEM[ADDR_WIDTH+1:2];
      dmem_we      = MemWrite_MEM & ~stall & ~reset & ~misaligned_c;
   end

   assign PCSrc_MEM     = Branch_MEM & Zero_MEM;
   assign PC_target_MEM = PC_next_MEM;

   data_memory #(
      .AW(ADDR_WIDTH)
   ) u_dmem (
      .clk   (clk),
      .reset (reset),
      .re    (~stall),
      .we    (dmem_we),
      .addr  (dmem_addr),
      .wdata (Read_Data_2_MEM),
      .rdata (Read_Data_WB)
   );

   // Next-state for the MEM/WB register; a misaligned access never writes back.
   always_comb begin
      alu_d        = resultadoALU_MEM;
      wreg_d       = Write_register_MEM;
      regwrite_d   = RegWrite_MEM & ~misaligned_c;
      memtoreg_d   = MemToReg_MEM;
      misaligned_d = misaligned_c;
   end

   // MEM/WB register: reset clears, stall holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_q        <= '0;
         wreg_q       <= '0;
         regwrite_q   <= 1'b0;
         memtoreg_q   <= 1'b0;
         misaligned_q <= 1'b0;
      end else if (!stall) begin
         alu_q        <= alu_d;
         wreg_q       <= wreg_d;
         regwrite_q   <= regwrite_d;
         memtoreg_q   <= memtoreg_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign resultadoALU_WB   = alu_q;
   assign Write_register_WB = wreg_q;
   assign RegWrite_WB       = regwrite_q;
   assign MemToReg_WB       = memtoreg_q;
   assign misaligned_WB     = misaligned_q;

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [31:0] PC_next_MEM;
   logic [31:0] resultadoALU_MEM;
   logic [31:0] Read_Data_2_MEM;
   logic        Branch_MEM, MemRead_MEM, MemToReg_MEM, MemWrite_MEM, RegWrite_MEM, Zero_MEM;
   logic [4:0]  Write_register_MEM;
   logic        PCSrc_MEM;
   logic [31:0] PC_target_MEM;
   logic [31:0] Read_Data_WB;
   logic [31:0] resultadoALU_WB;
   logic [4:0]  Write_register_WB;
   logic        RegWrite_WB, MemToReg_WB, misaligned_WB;

   int tests_run = 0;
   int tests_failed = 0;

   mem_wb_stage #(.ADDR_WIDTH(8)) dut (
      .clk                (clk),
      .reset              (reset),
      .stall              (stall),
      .PC_next_MEM        (PC_next_MEM),
      .resultadoALU_MEM   (resultadoALU_MEM),
      .Read_Data_2_MEM    (Read_Data_2_MEM),
      .Branch_MEM         (Branch_MEM),
      .MemRead_MEM        (MemRead_MEM),
      .MemToReg_MEM       (MemToReg_MEM),
      .MemWrite_MEM       (MemWrite_MEM),
      .RegWrite_MEM       (RegWrite_MEM),
      .Zero_MEM           (Zero_MEM),
      .Write_register_MEM (Write_register_MEM),
      .PCSrc_MEM          (PCSrc_MEM),
      .PC_target_MEM      (PC_target_MEM),
      .Read_Data_WB       (Read_Data_WB),
      .resultadoALU_WB    (resultadoALU_WB),
      .Write_register_WB  (Write_register_WB),
      .RegWrite_WB        (RegWrite_WB),
      .MemToReg_WB        (MemToReg_WB),
      .misaligned_WB      (misaligned_WB)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction in MEM (no stall, no branch).
   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] dst,
                        input logic m2r, input logic rw);
      stall              = 1'b0;
      MemRead_MEM        = rd;
      MemWrite_MEM       = wr;
      resultadoALU_MEM   = addr;
      Read_Data_2_MEM    = wdata;
      Write_register_MEM = dst;
      MemToReg_MEM       = m2r;
      RegWrite_MEM       = rw;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b1, 32'h30, 32'hA5A5_0F0F, 5'd0, 1'b0, 1'b0);
      step();
      reset              = 1'b1;
      stall              = 1'($urandom);
      PC_next_MEM        = $urandom;
      resultadoALU_MEM   = 32'h30;
      Read_Data_2_MEM    = $urandom | 32'h1;
      Branch_MEM         = 1'($urandom);
      Zero_MEM           = 1'($urandom);
      MemRead_MEM        = 1'b1;
      MemWrite_MEM       = 1'b1;
      MemToReg_MEM       = 1'b1;
      RegWrite_MEM       = 1'b1;
      Write_register_MEM = 5'($urandom_range(1, 31));
      step();
      reset = 1'b0;
      tests_run++; if (Read_Data_WB !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got %h want 0", Read_Data_WB); end
      tests_run++; if (resultadoALU_WB !== 32'h0) begin tests_failed++; $display("FAIL reset_alu got %h want 0", resultadoALU_WB); end
      tests_run++; if (Write_register_WB !== 5'h0) begin tests_failed++; $display("FAIL reset_wreg got %h want 0", Write_register_WB); end
      tests_run++; if (RegWrite_WB !== 1'b0) begin tests_failed++; $display("FAIL reset_regwrite got %b want 0", RegWrite_WB); end
      tests_run++; if (MemToReg_WB !== 1'b0) begin tests_failed++; $display("FAIL reset_memtoreg got %b want 0", MemToReg_WB); end
      tests_run++; if (misaligned_WB !== 1'b0) begin tests_failed++; $display("FAIL reset_misaligned got %b want 0", misaligned_WB); end
      Branch_MEM = 1'b0;
      Zero_MEM   = 1'b0;
      drive(1'b1, 1'b0, 32'h30, 32'h0, 5'd4, 1'b1, 1'b1);
      step();
      tests_run++; if (Read_Data_WB !== 32'hA5A5_0F0F) begin tests_failed++; $display("FAIL reset_mem_probe got %h want a5a50f0f", Read_Data_WB); end
   endtask

   task automatic test_store_load();
      drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
      step();
      tests_run++; if (MemToReg_WB !== 1'b0) begin tests_failed++; $display("FAIL store_memtoreg got %b want 0", MemToReg_WB); end
      tests_run++; if (RegWrite_WB !== 1'b0) begin tests_failed++; $display("FAIL store_regwrite got %b want 0", RegWrite_WB); end
      drive(1'b1, 1'b0, 32'h10, 32'h0, 5'd7, 1'b1, 1'b1);
      step();
      tests_run++; if (Read_Data_WB !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL load_rdata got %h want deadbeef", Read_Data_WB); end
      tests_run++; if (MemToReg_WB !== 1'b1) begin tests_failed++; $display("FAIL load_memtoreg got %b want 1", MemToReg_WB); end
      tests_run++; if (Write_register_WB !== 5'd7) begin tests_failed++; $display("FAIL load_wreg got %0d want 7", Write_register_WB); end
      tests_run++; if (RegWrite_WB !== 1'b1) begin tests_failed++; $display("FAIL load_regwrite got %b want 1", RegWrite_WB); end
      tests_run++; if (resultadoALU_WB !== 32'h10) begin tests_failed++; $display("FAIL load_alu got %h want 10", resultadoALU_WB); end
   endtask

   task automatic test_misaligned();
      drive(1'b0, 1'b1, 32'h400, 32'h0BAD_F00D, 5'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b0, 32'h402, 32'h0, 5'd9, 1'b1, 1'b1);
      step();
      tests_run++; if (misaligned_WB !== 1'b1) begin tests_failed++; $display("FAIL mis_load_flag got %b want 1", misaligned_WB); end
      tests_run++; if (RegWrite_WB !== 1'b0) begin tests_failed++; $display("FAIL mis_load_regwrite got %b want 0", RegWrite_WB); end
      tests_run++; if (resultadoALU_WB !== 32'h402) begin tests_failed++; $display("FAIL mis_load_alu got %h want 402", resultadoALU_WB); end
      drive(1'b0, 1'b1, 32'h402, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
      step();
      tests_run++; if (misaligned_WB !== 1'b1) begin tests_failed++; $display("FAIL mis_store_flag got %b want 1", misaligned_WB); end
      drive(1'b0, 1'b0, 32'h403, 32'h0, 5'd2, 1'b0, 1'b1);
      step();
      tests_run++; if (misaligned_WB !== 1'b0) begin tests_failed++; $display("FAIL mis_pulse got %b want 0", misaligned_WB); end
      tests_run++; if (RegWrite_WB !== 1'b1) begin tests_failed++; $display("FAIL alu_op_regwrite got %b want 1", RegWrite_WB); end
      drive(1'b1, 1'b0, 32'h400, 32'h0, 5'd9, 1'b1, 1'b1);
      step();
      tests_run++; if (Read_Data_WB !== 32'h0BAD_F00D) begin tests_failed++; $display("FAIL mis_store_nowrite got %h want 0badf00d", Read_Data_WB); end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b1, 32'h400, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b0, 32'h000, 32'h0, 5'd5, 1'b1, 1'b1);
      step();
      tests_run++; if (Read_Data_WB !== 32'h1234_5678) begin tests_failed++; $display("FAIL wrap_rdata got %h want 12345678", Read_Data_WB); end
   endtask

   task automatic test_stall();
      logic [31:0] data_seq [4];
      data_seq[0] = 32'h1111_1111;
      data_seq[1] = 32'h2222_2222;
      data_seq[2] = 32'h3333_3333;
      data_seq[3] = 32'h4444_4444;
      drive(1'b1, 1'b0, 32'h10, 32'h0, 5'd3, 1'b1, 1'b1);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 32'h20, data_seq[i], 5'd0, 1'b0, 1'b0);
         stall = 1'b1;
         step();
         tests_run++; if (Read_Data_WB !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL stall_rdata[%0d] got %h want deadbeef", i, Read_Data_WB); end
         tests_run++; if (Write_register_WB !== 5'd3 || MemToReg_WB !== 1'b1 || RegWrite_WB !== 1'b1 || resultadoALU_WB !== 32'h10)
            begin tests_failed++; $display("FAIL stall_ctrl[%0d] got wreg=%0d m2r=%b rw=%b alu=%h want 3 1 1 10", i, Write_register_WB, MemToReg_WB, RegWrite_WB, resultadoALU_WB); end
      end
      drive(1'b0, 1'b1, 32'h20, data_seq[3], 5'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b0, 32'h20, 32'h0, 5'd6, 1'b1, 1'b1);
      step();
      tests_run++; if (Read_Data_WB !== 32'h4444_4444) begin tests_failed++; $display("FAIL stall_mem got %h want 44444444", Read_Data_WB); end
   endtask

   task automatic test_back_to_back();
      drive(1'b0, 1'b1, 32'h44, 32'hCAFE_0001, 5'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b1, 32'h44, 32'hCAFE_0002, 5'd8, 1'b1, 1'b1);
      step();
      tests_run++; if (Read_Data_WB !== 32'hCAFE_0001) begin tests_failed++; $display("FAIL rw_read_first got %h want cafe0001", Read_Data_WB); end
      drive(1'b1, 1'b0, 32'h44, 32'h0, 5'd8, 1'b1, 1'b1);
      step();
      tests_run++; if (Read_Data_WB !== 32'hCAFE_0002) begin tests_failed++; $display("FAIL rw_new_data got %h want cafe0002", Read_Data_WB); end
   endtask

   task automatic test_branch();
      PC_next_MEM = 32'h0040_0080;
      Branch_MEM  = 1'b1;
      Zero_MEM    = 1'b0;
      #1;
      tests_run++; if (PCSrc_MEM !== 1'b0) begin tests_failed++; $display("FAIL br_z0 got %b want 0", PCSrc_MEM); end
      tests_run++; if (PC_target_MEM !== 32'h0040_0080) begin tests_failed++; $display("FAIL br_target got %h want 00400080", PC_target_MEM); end
      Zero_MEM = 1'b1;
      #1;
      tests_run++; if (PCSrc_MEM !== 1'b1) begin tests_failed++; $display("FAIL br_z1 got %b want 1", PCSrc_MEM); end
      stall = 1'b1;
      #1;
      tests_run++; if (PCSrc_MEM !== 1'b1) begin tests_failed++; $display("FAIL br_stall got %b want 1", PCSrc_MEM); end
      Zero_MEM = 1'b0;
      #1;
      tests_run++; if (PCSrc_MEM !== 1'b0) begin tests_failed++; $display("FAIL br_z0_again got %b want 0", PCSrc_MEM); end
      Branch_MEM  = 1'b0;
      Zero_MEM    = 1'b1;
      PC_next_MEM = 32'hFFFF_FFFC;
      #1;
      tests_run++; if (PCSrc_MEM !== 1'b0) begin tests_failed++; $display("FAIL br_nobranch got %b want 0", PCSrc_MEM); end
      tests_run++; if (PC_target_MEM !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL br_target2 got %h want fffffffc", PC_target_MEM); end
      stall    = 1'b0;
      Zero_MEM = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      PC_next_MEM = 32'h0;
      Branch_MEM  = 1'b0;
      Zero_MEM    = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      step();
      step();
      reset = 1'b0;
      test_reset();
      test_store_load();
      test_misaligned();
      test_wrap();
      test_stall();
      test_back_to_back();
      test_branch();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_mem_wb_stage

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register. It performs word loads and stores against an internal synchronous data memory. It resolves the branch decision (PCSrc) for the fetch stage and registers load data, ALU result and write-back controls into the WB stage. It supports a hazard-unit stall and flags misaligned accesses.

## Interface
- ADDR_WIDTH, 8, word-address bits of data memory (2^ADDR_WIDTH 32-bit words)
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  synchronous, active-high
- stall  input  1  hold MEM/WB register; instruction in MEM does not commit this cycle
- PC_next_MEM  input  32  branch target computed in EX
- resultadoALU_MEM  input  32  ALU result / memory byte address
- Read_Data_2_MEM  input  32  store data
- Branch_MEM, MemRead_MEM, MemToReg_MEM, MemWrite_MEM, RegWrite_MEM, Zero_MEM  input  1 each  EX/MEM controls
- Write_register_MEM  input  5  destination register index
- PCSrc_MEM  output  1  combinational: Branch_MEM & Zero_MEM
- PC_target_MEM  output  32  combinational pass-through of PC_next_MEM
- Read_Data_WB  output  32  loaded word
- resultadoALU_WB  output  32  registered ALU result
- Write_register_WB  output  5  registered destination index
- RegWrite_WB, MemToReg_WB  output  1 each  registered controls
- misaligned_WB  output  1  registered misaligned-access flag

## Operation
- Word address = resultadoALU_MEM[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap modulo memory size.
- misaligned = (MemRead_MEM | MemWrite_MEM) & (resultadoALU_MEM[1:0] != 0).
- Store: commits on the rising edge where MemWrite_MEM=1, stall=0, reset=0 and not misaligned. Misaligned stores never write.
- Load: synchronous read, read-first. When MemRead_MEM and MemWrite_MEM are both 1, the write happens and Read_Data_WB returns the pre-write word.
- Commit edge (stall=0, reset=0): the WB register captures resultadoALU, Write_register, MemToReg and misaligned. RegWrite_WB is captured as RegWrite_MEM & ~misaligned.
- Stall edge (stall=1, reset=0): all WB outputs, including Read_Data_WB, hold their values. No memory write occurs. The read address is not re-sampled.
- PCSrc_MEM is asserted whenever Branch_MEM & Zero_MEM, independent of stall. The hazard unit qualifies it.
- The memory array is not reset; simulation initial contents are zero.

## Timing
- Reset: on the edge with reset=1, Read_Data_WB, resultadoALU_WB, Write_register_WB, RegWrite_WB, MemToReg_WB and misaligned_WB all become 0. No memory write occurs that edge.
- Reset wins over stall and over MemWrite.
- Latency: an instruction present in MEM at edge N (stall=0) appears on the WB outputs after edge N.
- Load data is valid in the same cycle as the other WB outputs.
- Store-then-load to the same address on consecutive commit edges: the load returns the new data.
- PCSrc_MEM / PC_target_MEM: zero-cycle combinational path from the inputs.
- misaligned_WB is a single-cycle pulse per offending instruction. It is held while stalled.

## Structure
- Shared pipeline_pkg holds:
  - REG_IDX_W = 5
  - DATA_W = 32
  - default DMEM_ADDR_WIDTH = 8
- Sub-module data_memory:
  - Inputs: clk, we, addr, wdata; output rdata.
  - Synchronous read-first RAM with a read-enable.
  - Read-enable is driven by ~stall.
- The mem_wb_stage top level holds:
  - the misaligned logic
  - the PCSrc logic
  - the MEM/WB register with reset and stall

## Test plan
- Reset with all inputs at random values -> every WB output reads 0 after the reset edge; a probe of a pre-written word confirms memory is unchanged.
- Store 0xDEADBEEF at address 0x10, then load from 0x10 on the next cycle -> Read_Data_WB=0xDEADBEEF, MemToReg_WB=1, Write_register_WB matches the load's destination.
- Load from 0x402 (misaligned) with RegWrite_MEM=1 -> misaligned_WB=1, RegWrite_WB=0; a store to 0x402 leaves word 0x100 unchanged.
- Address wrap: store 0x12345678 at 0x400 with ADDR_WIDTH=8 -> a load from 0x000 returns 0x12345678.
- Stall for 3 cycles during a store to 0x20 with changing Read_Data_2_MEM -> WB outputs hold; memory holds only the value presented on the first non-stalled edge.
- Branch_MEM=1 with Zero_MEM toggling 0/1 -> PCSrc_MEM follows in the same cycle; PC_target_MEM equals PC_next_MEM.
